clint_timer: RTL and testbench

//  Core-local interruptor feeding csr_file: keeps 64-bit mtime, 64-bit mtimecmp and MSIP.

---
 rtl/clint_pkg.sv | 45 ++++
 rtl/clint_timer_if.sv | 21 ++
 rtl/clint_mtime_counter.sv | 60 ++++++
 rtl/clint_timer.sv | 88 ++++++++
 tb/tb_clint_timer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clint_pkg.sv
// Shared types, register offsets and helpers for the core-local interruptor.
package clint_pkg;

  typedef logic [31:0] clint_word_t;
  typedef logic [3:0]  clint_be_t;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } clint_reg_t;

  function automatic clint_word_t apply_be(clint_word_t old, clint_word_t wdata, clint_be_t be);
    clint_word_t res;
    res = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Word address in, register select out; the two byte-offset bits never reach here.
  function automatic clint_reg_t decode(logic [13:0] word);
    logic [15:0] off;
    off = {word, 2'b00};
    case (off)
      MSIP_OFF:        return REG_MSIP;
      MTIMECMP_LO_OFF: return REG_CMP_LO;
      MTIMECMP_HI_OFF: return REG_CMP_HI;
      MTIME_LO_OFF:    return REG_TIME_LO;
      MTIME_HI_OFF:    return REG_TIME_HI;
      default:         return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Memory-mapped slave bus for the CLINT: request side plus registered read return.
interface clint_timer_if;
  logic                     valid;
  logic                     ready;
  logic                     we;
  logic [15:0]              addr;
  clint_pkg::clint_word_t   wdata;
  clint_pkg::clint_be_t     be;
  clint_pkg::clint_word_t   rdata;
  logic                     rvalid;

  modport master (
    output valid, we, addr, wdata, be,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  valid, we, addr, wdata, be,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/clint_mtime_counter.sv
// Prescaler plus 64-bit mtime with byte-strobed word writes.
// CLINT_PRESCALE_EN builds the prescaler; otherwise mtime advances every enabled cycle.
module clint_mtime_counter
  import clint_pkg::*;
#(
  parameter logic [15:0] PRESCALE  = 16'd1,
  parameter logic [63:0] MTIME_RST = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  clint_be_t   be,
  input  clint_word_t wdata,
  output logic [63:0] mtime
);

  logic        tick;
  logic [63:0] inc;
  logic [63:0] mtime_next;

`ifdef CLINT_PRESCALE_EN
  logic [15:0] cnt;
  logic        at_wrap;

  assign at_wrap = (cnt == (PRESCALE - 16'd1));
  assign tick    = tick_en && at_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick_en) begin
      cnt <= at_wrap ? '0 : cnt + 16'd1;
    end
  end
`else
  logic [15:0] unused_prescale;

  assign unused_prescale = PRESCALE;
  assign tick            = tick_en;
`endif

  // Increment first, then overlay written bytes so unwritten bytes keep the ticked value.
  always_comb begin
    inc        = mtime + {63'd0, tick};
    mtime_next = inc;
    if (wr_lo) mtime_next[31:0]  = apply_be(inc[31:0], wdata, be);
    if (wr_hi) mtime_next[63:32] = apply_be(inc[63:32], wdata, be);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= MTIME_RST;
    end else begin
      mtime <= mtime_next;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/MSIP behind a never-stalling slave port.
// Optional prescaler is enabled with the CLINT_PRESCALE_EN macro.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [15:0] PRESCALE  = 16'd1,
  parameter logic [63:0] MTIME_RST = 64'd0
) (
  input  logic            clk,
  input  logic            reset,
  clint_timer_if.slave    bus,
  output logic            timer_int,
  output logic            soft_int
);

  logic        accept;
  logic        wr;
  logic        rd;
  clint_reg_t  sel;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  clint_word_t rd_word;
  logic [1:0]  unused_addr_lo;

  assign bus.ready      = 1'b1;
  assign accept         = bus.valid && bus.ready;
  assign wr             = accept && bus.we;
  assign rd             = accept && !bus.we;
  assign sel            = decode(bus.addr[15:2]);
  assign unused_addr_lo = bus.addr[1:0];

  clint_mtime_counter #(
    .PRESCALE  (PRESCALE),
    .MTIME_RST (MTIME_RST)
  ) u_mtime (
    .clk     (clk),
    .reset   (reset),
    .tick_en (1'b1),
    .wr_lo   (wr && (sel == REG_TIME_LO)),
    .wr_hi   (wr && (sel == REG_TIME_HI)),
    .be      (bus.be),
    .wdata   (bus.wdata),
    .mtime   (mtime)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (wr) begin
      case (sel)
        REG_MSIP:   if (bus.be[0]) msip <= bus.wdata[0];
        REG_CMP_LO: mtimecmp[31:0]  <= apply_be(mtimecmp[31:0], bus.wdata, bus.be);
        REG_CMP_HI: mtimecmp[63:32] <= apply_be(mtimecmp[63:32], bus.wdata, bus.be);
        default:    ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_MSIP:    rd_word = {31'd0, msip};
      REG_CMP_LO:  rd_word = mtimecmp[31:0];
      REG_CMP_HI:  rd_word = mtimecmp[63:32];
      REG_TIME_LO: rd_word = mtime[31:0];
      REG_TIME_HI: rd_word = mtime[63:32];
      default:     rd_word = '0;
    endcase
  end

  // Read data is sampled from pre-edge state, so same-cycle writes/ticks are not visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      timer_int  <= 1'b0;
    end else begin
      bus.rvalid <= rd;
      if (rd) bus.rdata <= rd_word;
      timer_int <= (mtime >= mtimecmp);
    end
  end

  assign soft_int = msip;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed steps plus random traffic against a reference model.
module tb_clint_timer;

`ifdef CLINT_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic timer_int;
  logic soft_int;

  clint_timer_if bus ();

  clint_timer #(
    .PRESCALE  (16'd4),
    .MTIME_RST (64'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .timer_int (timer_int),
    .soft_int  (soft_int)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0]     m_time;
  logic [63:0]     m_cmp;
  logic            m_msip;
  longint unsigned m_cyc;
  logic            e_tint;
  logic            e_rvalid;
  logic [31:0]     e_rdata;

  function automatic int reg_of(logic [15:0] a);
    logic [15:0] w;
    w = {a[15:2], 2'b00};
    case (w)
      16'h0000: return 1;
      16'h4000: return 2;
      16'h4004: return 3;
      16'hBFF8: return 4;
      16'hBFFC: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(int r, logic [63:0] t, logic [63:0] c, logic s);
    case (r)
      1: return {31'd0, s};
      2: return c[31:0];
      3: return c[63:32];
      4: return t[31:0];
      5: return t[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] time_next(logic [63:0] t, longint unsigned cyc, logic wen, int r,
                                            logic [31:0] d, logic [3:0] be);
    logic [63:0] n;
    n = t;
    if ((cyc % longint'(P)) == longint'(P - 1)) n = t + 64'd1;
    if (wen && r == 4) n[31:0]  = merge(n[31:0], d, be);
    if (wen && r == 5) n[63:32] = merge(n[63:32], d, be);
    return n;
  endfunction

  function automatic logic [63:0] cmp_next(logic [63:0] c, logic wen, int r, logic [31:0] d, logic [3:0] be);
    logic [63:0] n;
    n = c;
    if (wen && r == 2) n[31:0]  = merge(n[31:0], d, be);
    if (wen && r == 3) n[63:32] = merge(n[63:32], d, be);
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_time   <= 64'd0;
      m_cmp    <= '1;
      m_msip   <= 1'b0;
      m_cyc    <= 0;
      e_tint   <= 1'b0;
      e_rvalid <= 1'b0;
      e_rdata  <= 32'd0;
    end else begin
      m_cyc    <= m_cyc + 1;
      e_tint   <= (m_time >= m_cmp);
      e_rvalid <= bus.valid && !bus.we;
      if (bus.valid && !bus.we) e_rdata <= model_read(reg_of(bus.addr), m_time, m_cmp, m_msip);
      m_time <= time_next(m_time, m_cyc, bus.valid && bus.we, reg_of(bus.addr), bus.wdata, bus.be);
      m_cmp  <= cmp_next(m_cmp, bus.valid && bus.we, reg_of(bus.addr), bus.wdata, bus.be);
      if (bus.valid && bus.we && reg_of(bus.addr) == 1 && bus.be[0]) m_msip <= bus.wdata[0];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ready", {63'd0, bus.ready}, 64'd1);
    chk("timer_int", {63'd0, timer_int}, {63'd0, e_tint});
    chk("soft_int", {63'd0, soft_int}, {63'd0, m_msip});
    chk("rvalid", {63'd0, bus.rvalid}, {63'd0, e_rvalid});
    chk("rdata", {32'd0, bus.rdata}, {32'd0, e_rdata});
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.valid = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.be = be;
    cycle();
    bus.valid = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    bus.valid = 1'b1; bus.we = 1'b0; bus.addr = a;
    cycle();
    bus.valid = 1'b0;
    d = bus.rdata;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a0;
    int n;

    reset = 1'b1;
    bus.valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    idle(2);
    chk("rst_timer_int", {63'd0, timer_int}, 64'd0);
    chk("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
    reset = 1'b0;

    // Reset values of mtimecmp and read latency
    rd(16'h4000, d);
    chk("cmp_lo_rst", {32'd0, d}, 64'hFFFF_FFFF);
    chk("rvalid_lat", {63'd0, bus.rvalid}, 64'd1);
    rd(16'h4004, d);
    chk("cmp_hi_rst", {32'd0, d}, 64'hFFFF_FFFF);
    cycle();
    chk("rvalid_pulse", {63'd0, bus.rvalid}, 64'd0);

    // Timer compare: rise after mtime reaches 0x20, drop after raising mtimecmp
    wr(16'h4000, 32'h20, 4'hF);
    wr(16'h4004, 32'h0, 4'hF);
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'h0, 4'hF);
    n = 0;
    while (timer_int !== 1'b1 && n < 1000) begin
      cycle();
      n++;
    end
    chk("tint_rise_window", {63'd0, (n >= 32*P - P + 2) && (n <= 32*P + 1)}, 64'd1);
    wr(16'h4004, 32'h1, 4'hF);
    chk("tint_hold_1cyc", {63'd0, timer_int}, 64'd1);
    cycle();
    chk("tint_drop", {63'd0, timer_int}, 64'd0);

    // MSIP
    wr(16'h0000, 32'h1, 4'hF);
    chk("soft_set", {63'd0, soft_int}, 64'd1);
    rd(16'h0002, d);
    chk("msip_read", {32'd0, d}, 64'h1);
    wr(16'h0000, 32'h0, 4'hF);
    chk("soft_clr", {63'd0, soft_int}, 64'd0);
    wr(16'h0000, 32'h1, 4'b1110);
    chk("soft_be0_off", {63'd0, soft_int}, 64'd0);
    rd(16'h1234, d);
    chk("hole_read", {32'd0, d}, 64'd0);

    // 64-bit wrap
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    idle(2 * P);
    rd(16'hBFFC, d);
    chk("wrap_hi", {32'd0, d}, 64'd0);
    rd(16'hBFF8, d);
    chk("wrap_lo_small", {63'd0, d <= 32'd1}, 64'd1);

    // Partial byte write on a tick cycle
    wr(16'hBFF8, 32'h0000_12FF, 4'hF);
    n = 0;
    while ((m_cyc % longint'(P)) != longint'(P - 1) && n < 16) begin
      cycle();
      n++;
    end
    chk("tick_align", {63'd0, n < 16}, 64'd1);
    wr(16'hBFF8, 32'h0000_0100, 4'b0001);
    rd(16'hBFF8, d);
    chk("be_tick_merge", {32'd0, d}, 64'h0000_1300);

    // One increment per P cycles
    rd(16'hBFF8, a0);
    idle(P - 1);
    rd(16'hBFF8, d);
    chk("rate", {32'd0, d - a0}, 64'd1);

    // Reset mid-operation with a read in flight
    bus.valid = 1'b1; bus.we = 1'b0; bus.addr = 16'hBFF8;
    cycle();
    bus.valid = 1'b0;
    reset = 1'b1;
    cycle();
    chk("midrst_rvalid", {63'd0, bus.rvalid}, 64'd0);
    chk("midrst_rdata", {32'd0, bus.rdata}, 64'd0);
    reset = 1'b0;
    for (int j = 1; j <= P + 1; j++) begin
      rd(16'hBFF8, d);
      chk("midrst_count", {32'd0, d}, (j == P + 1) ? 64'd1 : 64'd0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      bus.valid = $urandom_range(0, 1);
      bus.we    = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: bus.addr = 16'h0000;
        1: bus.addr = 16'h4000;
        2: bus.addr = 16'h4004;
        3: bus.addr = 16'hBFF8;
        4: bus.addr = 16'hBFFC;
        default: bus.addr = 16'($urandom);
      endcase
      bus.addr[1:0] = 2'($urandom);
      bus.wdata = $urandom;
      bus.be    = 4'($urandom);
      cycle();
    end
    reset = 1'b0;
    bus.valid = 1'b0;
    bus.we = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
